// File: rtl/exe_alu_mc.sv
// Multi-cycle execute-stage ALU: valid/ready in and out, registered result and NZCV flags, shift-add MUL/MLA.
// Optional macro EXE_ALU_EARLY_TERM_EN: the multiply loop exits once the remaining multiplier bits are all zero.
module exe_alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       EXE_CMD,
  input  logic [WIDTH-1:0] Val1,
  input  logic [WIDTH-1:0] Val2,
  input  logic [WIDTH-1:0] Val3,
  input  logic [3:0]       Status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Res,
  output logic [3:0]       Flags,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [WIDTH-1:0] val3_q, val3_d, res_q, res_d;
  logic             mla_q, mla_d, out_valid_q, out_valid_d;
  logic [1:0]       cv_q, cv_d;
  logic [3:0]       flags_q, flags_d;
`ifndef EXE_ALU_EARLY_TERM_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic             accept, is_mul, arith, sub_op, cin, known;
  logic [WIDTH-1:0] op_b, alu_res, mla_sum;
  logic [WIDTH:0]   sum;
  logic [3:0]       alu_flags;
  logic             unused_status;

  assign unused_status = ^Status[3:2];
  assign in_ready  = (state_q == IDLE) & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign is_mul    = (EXE_CMD[3:1] == 3'b101);
  assign busy      = (state_q == MULT);
  assign out_valid = out_valid_q;
  assign ALU_Res   = res_q;
  assign Flags     = flags_q;
  assign mla_sum   = acc_q + (mla_q ? val3_q : '0);

  // Subtraction is Val1 + ~Val2 + carry-in, so the carry out is already NOT-borrow.
  always_comb begin
    arith  = 1'b0;
    sub_op = 1'b0;
    cin    = 1'b0;
    case (EXE_CMD)
      4'b0010: arith = 1'b1;
      4'b0011: begin arith = 1'b1; cin = Status[1]; end
      4'b0100: begin arith = 1'b1; sub_op = 1'b1; cin = 1'b1; end
      4'b0101: begin arith = 1'b1; sub_op = 1'b1; cin = Status[1]; end
      default: ;
    endcase
    op_b = sub_op ? ~Val2 : Val2;
    sum  = {1'b0, Val1} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
  end

  always_comb begin
    alu_res = '0;
    known   = 1'b1;
    case (EXE_CMD)
      4'b0001: alu_res = Val2;
      4'b1001: alu_res = ~Val2;
      4'b0010, 4'b0011, 4'b0100, 4'b0101: alu_res = sum[WIDTH-1:0];
      4'b0110: alu_res = Val1 & Val2;
      4'b0111: alu_res = Val1 | Val2;
      4'b1000: alu_res = Val1 ^ Val2;
      default: known = 1'b0;
    endcase
    if (known)
      alu_flags = {alu_res[WIDTH-1], (alu_res == '0), arith & sum[WIDTH],
                   arith & (Val1[WIDTH-1] == op_b[WIDTH-1]) & (sum[WIDTH-1] != Val1[WIDTH-1])};
    else
      alu_flags = 4'b0100;
  end

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    val3_d      = val3_q;
    mla_d       = mla_q;
    cv_d        = cv_q;
    res_d       = res_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q & ~out_ready;
`ifndef EXE_ALU_EARLY_TERM_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept && is_mul) begin
          mcand_d  = Val1;
          mplier_d = Val2;
          acc_d    = '0;
          val3_d   = Val3;
          mla_d    = EXE_CMD[0];
          cv_d     = Status[1:0];
          state_d  = MULT;
`ifdef EXE_ALU_EARLY_TERM_EN
          if (Val2 == '0) state_d = DONE;
`else
          cnt_d    = CNT_W'(WIDTH - 1);
`endif
        end else if (accept) begin
          res_d       = alu_res;
          flags_d     = alu_flags;
          out_valid_d = 1'b1;
        end
      end
      MULT: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
`ifdef EXE_ALU_EARLY_TERM_EN
        if (mplier_q[WIDTH-1:1] == '0) state_d = DONE;
`else
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = DONE;
`endif
      end
      DONE: begin
        res_d       = mla_sum;
        flags_d     = {mla_sum[WIDTH-1], (mla_sum == '0), cv_q};
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      val3_q      <= '0;
      mla_q       <= 1'b0;
      cv_q        <= 2'b00;
      res_q       <= '0;
      flags_q     <= 4'b0000;
      out_valid_q <= 1'b0;
`ifndef EXE_ALU_EARLY_TERM_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      val3_q      <= val3_d;
      mla_q       <= mla_d;
      cv_q        <= cv_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
`ifndef EXE_ALU_EARLY_TERM_EN
      cnt_q       <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_exe_alu_mc.sv
// Randomised and directed bench for exe_alu_mc (WIDTH=32) against an arithmetic reference model.
module tb_exe_alu_mc;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]    EXE_CMD, Status, Flags;
  logic [W-1:0]  Val1, Val2, Val3, ALU_Res;
  int            total = 0;
  int            bad = 0;

  exe_alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .EXE_CMD(EXE_CMD),
    .Val1(Val1), .Val2(Val2), .Val3(Val3), .Status(Status), .out_valid(out_valid),
    .out_ready(out_ready), .ALU_Res(ALU_Res), .Flags(Flags), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {result, N, Z, C, V} from plain integer arithmetic.
  function automatic logic [35:0] model(input logic [3:0] cmd, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c3,
                                        input logic [3:0] st);
    logic [63:0] ua, ub, uc, p;
    longint      sa, sb, d;
    logic [31:0] r;
    logic        cf, vf;
    ua = {32'b0, a};
    ub = {32'b0, b};
    uc = {63'b0, st[1]};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cf = 1'b0;
    vf = 1'b0;
    d  = 0;
    r  = 32'h0;
    case (cmd)
      4'h1: r = b;
      4'h9: r = ~b;
      4'h6: r = a & b;
      4'h7: r = a | b;
      4'h8: r = a ^ b;
      4'h2, 4'h3: begin
        if (cmd == 4'h2) uc = 64'd0;
        p  = ua + ub + uc;
        r  = p[31:0];
        cf = p > 64'hFFFF_FFFF;
        d  = sa + sb + longint'(uc);
        vf = d != longint'($signed(d[31:0]));
      end
      4'h4, 4'h5: begin
        uc = (cmd == 4'h4) ? 64'd0 : {63'b0, ~st[1]};
        r  = a - b - uc[31:0];
        cf = ua >= ub + uc;
        d  = sa - sb - longint'(uc);
        vf = d != longint'($signed(d[31:0]));
      end
      4'hA, 4'hB: begin
        p  = ua * ub + ((cmd == 4'hB) ? {32'b0, c3} : 64'd0);
        r  = p[31:0];
        cf = st[1];
        vf = st[0];
      end
      default: return {32'h0, 4'b0100};
    endcase
    return {r, r[31], r == 32'h0, cf, vf};
  endfunction

  function automatic int exp_lat(input logic [3:0] cmd, input logic [31:0] b);
    if (cmd == 4'hA || cmd == 4'hB) begin
`ifdef EXE_ALU_EARLY_TERM_EN
      for (int i = 31; i >= 0; i--) if (b[i]) return i + 3;
      return 2;
`else
      return W + 2;
`endif
    end
    return 1;
  endfunction

  task automatic run_op(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c3, input logic [3:0] st);
    logic [35:0] m;
    int          lat, el, n, busy_err, rdy_err;
    m  = model(cmd, a, b, c3, st);
    el = exp_lat(cmd, b);
    @(negedge clk);
    EXE_CMD = cmd; Val1 = a; Val2 = b; Val3 = c3; Status = st; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check($sformatf("%s_accept_rdy", tag), in_ready, 1);
    @(posedge clk);
    lat = 0; busy_err = 0; rdy_err = 0;
    while (lat < 100) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (out_valid) break;
      if (in_ready) rdy_err++;
      if (busy !== (lat <= el - 2)) busy_err++;
    end
    $display("op %s cmd=%h a=%h b=%h c=%h st=%b -> res=%h flags=%b lat=%0d", tag, cmd, a, b, c3,
             st, ALU_Res, Flags, lat);
    check($sformatf("%s_lat", tag), lat, el);
    check($sformatf("%s_res", tag), ALU_Res, m[35:4]);
    check($sformatf("%s_flags", tag), Flags, m[3:0]);
    if (el > 1) begin
      check($sformatf("%s_busy_seq", tag), busy_err, 0);
      check($sformatf("%s_rdy_low", tag), rdy_err, 0);
    end
  endtask

  initial begin
    logic [35:0] m;
    logic [31:0] a, b;
    logic [3:0]  cmd;
    int          n, errs;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    EXE_CMD = 4'h0; Val1 = '0; Val2 = '0; Val3 = '0; Status = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_res", ALU_Res, 0);
    check("rst_flags", Flags, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    run_op("add_ovf", 4'h2, 32'h7FFF_FFFF, 32'h1, 32'h0, 4'b0000);
    run_op("sbc", 4'h5, 32'd5, 32'd3, 32'h0, 4'b0000);
    run_op("sub_neg", 4'h4, 32'd3, 32'd5, 32'h0, 4'b0000);
    run_op("mul", 4'hA, 32'h0001_0001, 32'h0001_0001, 32'h0, 4'b0011);
    run_op("mul_zero", 4'hA, 32'h1234_5678, 32'h0, 32'h0, 4'b0000);
    run_op("unk_f", 4'hF, 32'h1234, 32'h5678, 32'h0, 4'b1111);
    run_op("unk_0", 4'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0010);

    // MLA with an ADD waiting behind it and the consumer stalled.
    @(negedge clk);
    EXE_CMD = 4'hB; Val1 = 32'd3; Val2 = 32'd4; Val3 = 32'hFFFF_FFF4; Status = 4'b0000;
    in_valid = 1'b1; out_ready = 1'b0;
    check("mla_accept_rdy", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    EXE_CMD = 4'h2; Val1 = 32'd10; Val2 = 32'd20; Val3 = 32'h0;
    n = 1; errs = 0;
    while (!out_valid && n < 100) begin
      if (in_ready) errs++;
      @(negedge clk);
      n++;
    end
    m = model(4'hB, 32'd3, 32'd4, 32'hFFFF_FFF4, 4'b0000);
    $display("op mla_blocked res=%h flags=%b lat=%0d", ALU_Res, Flags, n);
    check("mla_lat", n, exp_lat(4'hB, 32'd4));
    check("mla_res", ALU_Res, m[35:4]);
    check("mla_flags", Flags, m[3:0]);
    check("mla_add_blocked", errs, 0);
    @(negedge clk);
    check("mla_hold_rdy", in_ready, 0);
    check("mla_hold_res", ALU_Res, m[35:4]);
    out_ready = 1'b1;
    #1;
    check("mla_release_rdy", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    $display("op add_after_mla res=%h flags=%b", ALU_Res, Flags);
    check("add_after_mla_valid", out_valid, 1);
    check("add_after_mla_res", ALU_Res, 32'd30);
    check("add_after_mla_flags", Flags, 4'b0000);

    // ORR result held under backpressure while an ADD waits.
    @(negedge clk);
    EXE_CMD = 4'h7; Val1 = 32'hF0F0_0000; Val2 = 32'h0000_0F0F; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    EXE_CMD = 4'h2; Val1 = 32'hFFFF_FFFF; Val2 = 32'd2;
    m = model(4'h7, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0, 4'b0000);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if (!out_valid || in_ready || ALU_Res !== m[35:4] || Flags !== m[3:0]) errs++;
      @(negedge clk);
    end
    $display("op orr_held res=%h flags=%b", ALU_Res, Flags);
    check("orr_res", ALU_Res, m[35:4]);
    check("orr_flags", Flags, m[3:0]);
    check("orr_hold_errs", errs, 0);
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    m = model(4'h2, 32'hFFFF_FFFF, 32'd2, 32'h0, 4'b0000);
    $display("op add_after_bp res=%h flags=%b", ALU_Res, Flags);
    check("add_after_bp_valid", out_valid, 1);
    check("add_after_bp_res", ALU_Res, m[35:4]);
    check("add_after_bp_flags", Flags, m[3:0]);

    // Reset in the middle of a multiply.
    @(negedge clk);
    EXE_CMD = 4'hA; Val1 = 32'd7; Val2 = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_mult_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("op rst_mid_mult out_valid=%b busy=%b in_ready=%b res=%h", out_valid, busy,
             in_ready, ALU_Res);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_res", ALU_Res, 0);
    check("abort_flags", Flags, 0);
    errs = 0;
    repeat (40) begin @(negedge clk); if (out_valid) errs++; end
    check("abort_no_result", errs, 0);

    for (int i = 0; i < 60; i++) begin
      cmd = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: a = 32'h7FFF_FFFF + 32'($urandom_range(0, 2));
        1: a = 32'($urandom_range(0, 7));
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 1) == 1) ? ($urandom >> $urandom_range(0, 31)) : a + 32'($urandom_range(0, 2)) - 32'd1;
      run_op($sformatf("rnd%0d", i), cmd, a, b, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
